bzled_regbank: RTL

BZLED_REGBANK -- requirements
Module: bzled_regbank

---
 rtl/bzled_regbank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bzled_regbank.sv
// Bus-mapped shadow/active register bank for the buzzer and RGB LED PWM stage.
// Shadow values move to the active outputs on PWM period wraps, either at once or as a ramp.
module bzled_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter logic [31:0] FREQ_RST  = 32'd100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ip_ADDR,
  input  logic [31:0] ip_WDATA,
  input  logic        ip_Write,
  input  logic        ip_Read,
  output logic [31:0] ip_RDATA,
  output logic        ip_RVALID,
  input  logic        PERIOD_END,
  output logic [31:0] FREQ_Cnt_Set,
  output logic [31:0] BZ_Puty_Set,
  output logic [31:0] LEDR_Puty_Set,
  output logic [31:0] LEDG_Puty_Set,
  output logic [31:0] LEDB_Puty_Set
);
  typedef enum logic [1:0] {StIdle, StWaitCommit, StRamping} state_e;

  state_e           state_q, state_d;
  // Entry 0 is the PWM period, entries 1..4 are BZ, R, G, B duties.
  logic [4:0][31:0] shadow_q, shadow_d, active_q, active_d, ramped;
  logic             auto_q, auto_d, commit_q, commit_d, ramp_q, ramp_d;
  logic             pending_q, pending_d;
  logic [31:0]      step_q, step_d;
  logic             wr_q, rd_q;
  logic             rd_v1_q, rvalid_q;
  logic [31:0]      rd_data1_q, rdata_q, rd_mux;
  logic             sel, wr_acc, rd_acc, do_commit, ramp_tick, ramp_done;
  logic [2:0]       idx;
  logic             unused_addr_lsb;

  function automatic logic [31:0] step_toward(input logic [31:0] cur, input logic [31:0] tgt,
                                              input logic [31:0] stp);
    logic [31:0] res;
    res = tgt;
    // Compare distances rather than adding first, so the step can never wrap past the target.
    if (stp != '0) begin
      if (cur < tgt && (tgt - cur) > stp) res = cur + stp;
      else if (cur > tgt && (cur - tgt) > stp) res = cur - stp;
    end
    return res;
  endfunction

  assign sel             = ip_ADDR[31:5] == BASE_ADDR[31:5];
  assign idx             = ip_ADDR[4:2];
  assign wr_acc          = ip_Write & ~wr_q & sel;
  assign rd_acc          = ip_Read & ~rd_q;
  assign do_commit       = PERIOD_END & pending_q & (auto_q | commit_q) &
                           (state_q == StWaitCommit);
  assign ramp_tick       = PERIOD_END & (state_q == StRamping);
  assign unused_addr_lsb = ^ip_ADDR[1:0];

  always_comb begin
    ramped = active_q;
    for (int i = 1; i < 5; i++) ramped[i] = step_toward(active_q[i], shadow_q[i], step_q);
  end

  assign ramp_done = ramped[4:1] == shadow_q[4:1];

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    auto_d    = auto_q;
    commit_d  = commit_q;
    ramp_d    = ramp_q;
    pending_d = pending_q;
    step_d    = step_q;

    if (do_commit) begin
      commit_d    = 1'b0;
      pending_d   = 1'b0;
      active_d[0] = shadow_q[0];
      if (ramp_q) begin
        active_d[4:1] = ramped[4:1];
        state_d       = ramp_done ? StIdle : StRamping;
      end else begin
        active_d[4:1] = shadow_q[4:1];
        state_d       = StIdle;
      end
    end else if (ramp_tick) begin
      active_d[4:1] = ramped[4:1];
      if (ramp_done) state_d = StIdle;
    end

    // The bus write lands after the commit, so a colliding commit saw the old shadows.
    if (wr_acc) begin
      unique case (idx)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
          shadow_d[idx] = ip_WDATA;
          if (state_q != StRamping) pending_d = 1'b1;
        end
        3'd5: begin
          auto_d   = ip_WDATA[0];
          commit_d = ip_WDATA[1];
          ramp_d   = ip_WDATA[2];
        end
        3'd7:    step_d = ip_WDATA;
        default: ;
      endcase
    end

    if (state_d == StIdle && pending_d) state_d = StWaitCommit;
  end

  always_comb begin
    rd_mux = '0;
    if (sel) begin
      unique case (idx)
        3'd5:    rd_mux = {29'd0, ramp_q, 1'b0, auto_q};
        3'd6:    rd_mux = {30'd0, state_q == StRamping, pending_q};
        3'd7:    rd_mux = step_q;
        default: rd_mux = shadow_q[idx];
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      shadow_q   <= '0;
      active_q   <= '0;
      shadow_q[0] <= FREQ_RST;
      active_q[0] <= FREQ_RST;
      auto_q     <= 1'b1;
      commit_q   <= 1'b0;
      ramp_q     <= 1'b0;
      pending_q  <= 1'b0;
      step_q     <= 32'd1;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rd_v1_q    <= 1'b0;
      rd_data1_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      auto_q     <= auto_d;
      commit_q   <= commit_d;
      ramp_q     <= ramp_d;
      pending_q  <= pending_d;
      step_q     <= step_d;
      wr_q       <= ip_Write;
      rd_q       <= ip_Read;
      rd_v1_q    <= rd_acc;
      rd_data1_q <= rd_acc ? rd_mux : '0;
      rvalid_q   <= rd_v1_q;
      rdata_q    <= rd_data1_q;
    end
  end

  assign ip_RDATA      = rdata_q;
  assign ip_RVALID     = rvalid_q;
  assign FREQ_Cnt_Set  = active_q[0];
  assign BZ_Puty_Set   = (active_q[1] > active_q[0]) ? active_q[0] : active_q[1];
  assign LEDR_Puty_Set = (active_q[2] > active_q[0]) ? active_q[0] : active_q[2];
  assign LEDG_Puty_Set = (active_q[3] > active_q[0]) ? active_q[0] : active_q[3];
  assign LEDB_Puty_Set = (active_q[4] > active_q[0]) ? active_q[0] : active_q[4];

endmodule
